// File: rtl/ram_arb_ctrl_if.sv
// Bundle of requester, clear and RAM-port signals for ram_arb_ctrl.
// master = client/RAM environment side, slave = the controller.
interface ram_arb_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  // Handshake: a requester raises REQn with WEn/ADn/DTn and holds all four
  // stable until it sees GNTn high (one-cycle pulse). The fields are taken on
  // the edge that starts the GNT cycle. A read answers with an RVALIDn pulse
  // one cycle after GNTn, while RDATA carries the RAM output. REQn may stay
  // high through GNTn to request another operation.
  logic          REQ0;
  logic          REQ1;
  logic          WE0;
  logic          WE1;
  logic [AW-1:0] AD0;
  logic [AW-1:0] AD1;
  logic [DW-1:0] DT0;
  logic [DW-1:0] DT1;
  logic          GNT0;
  logic          GNT1;
  logic          RVALID0;
  logic          RVALID1;
  logic [DW-1:0] RDATA;
  logic          CLR;
  logic          BUSY;
  logic          M_RD_EN;
  logic          M_WR_EN;
  logic [AW-1:0] M_RD_AD;
  logic [AW-1:0] M_WR_AD;
  logic [DW-1:0] M_WR_DT;
  logic [DW-1:0] M_RD_DT;

  modport master (
    output REQ0, REQ1, WE0, WE1, AD0, AD1, DT0, DT1, CLR, M_RD_DT,
    input  GNT0, GNT1, RVALID0, RVALID1, RDATA, BUSY,
           M_RD_EN, M_WR_EN, M_RD_AD, M_WR_AD, M_WR_DT
  );

  modport slave (
    input  REQ0, REQ1, WE0, WE1, AD0, AD1, DT0, DT1, CLR, M_RD_DT,
    output GNT0, GNT1, RVALID0, RVALID1, RDATA, BUSY,
           M_RD_EN, M_WR_EN, M_RD_AD, M_WR_AD, M_WR_DT
  );
endinterface

// File: rtl/ram_arb_ctrl.sv
// Two-requester arbiter for a shared sync RAM with a bulk zero-fill sequencer.
// Define RAM_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins ties).
module ram_arb_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic               CLK,
  input  logic               RST,
  ram_arb_ctrl_if.slave      bus,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  localparam logic [AW-1:0] LAST_AD = {AW{1'b1}};
  localparam logic [AW-1:0] ONE_AD  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ZERO_AD = '0;
  localparam logic [DW-1:0] ZERO_DT = '0;

  logic [1:0]    state;
  logic          clr_pend;
  logic          busy_q;
  logic [AW-1:0] clr_cnt;

  logic          gnt0_q;
  logic          gnt1_q;
  logic          rvalid0_q;
  logic          rvalid1_q;
  logic          rd_en_q;
  logic          wr_en_q;
  logic [AW-1:0] rd_ad_q;
  logic [AW-1:0] wr_ad_q;
  logic [DW-1:0] wr_dt_q;

  logic          start_clr;
  logic          start_op;
  logic          pick1;
  logic          sel_we;
  logic [AW-1:0] sel_ad;
  logic [DW-1:0] sel_dt;

  always_comb begin
    start_clr = (state == IDLE) && (clr_pend || bus.CLR);
    start_op  = (state == IDLE) && !clr_pend && !bus.CLR && (bus.REQ0 || bus.REQ1);
  end

`ifdef RAM_ARB_FIXED_PRI_EN
  always_comb pick1 = bus.REQ1 && !bus.REQ0;
`else
  // last_q names the previous winner; on a tie the other requester goes.
  logic last_q;

  always_comb pick1 = bus.REQ1 && (!bus.REQ0 || !last_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= 1'b1;
    end else if (start_op) begin
      last_q <= pick1;
    end
  end
`endif

  always_comb begin
    sel_we = pick1 ? bus.WE1 : bus.WE0;
    sel_ad = pick1 ? bus.AD1 : bus.AD0;
    sel_dt = pick1 ? bus.DT1 : bus.DT0;
  end

  // Command outputs default to 0 every cycle and are only raised for the one
  // cycle they are meant to be seen by the RAM or a requester.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      clr_pend  <= 1'b0;
      busy_q    <= 1'b0;
      clr_cnt   <= ZERO_AD;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_ad_q   <= ZERO_AD;
      wr_ad_q   <= ZERO_AD;
      wr_dt_q   <= ZERO_DT;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_ad_q   <= ZERO_AD;
      wr_ad_q   <= ZERO_AD;
      wr_dt_q   <= ZERO_DT;
      rvalid0_q <= gnt0_q && rd_en_q;
      rvalid1_q <= gnt1_q && rd_en_q;

      case (state)
        IDLE: begin
          if (start_clr) begin
            state    <= CLEAR;
            clr_pend <= 1'b0;
            busy_q   <= 1'b1;
            clr_cnt  <= ZERO_AD;
            wr_en_q  <= 1'b1;
            wr_ad_q  <= ZERO_AD;
          end else if (start_op) begin
            state  <= ISSUE;
            gnt0_q <= !pick1;
            gnt1_q <= pick1;
            if (sel_we) begin
              wr_en_q <= 1'b1;
              wr_ad_q <= sel_ad;
              wr_dt_q <= sel_dt;
            end else begin
              rd_en_q <= 1'b1;
              rd_ad_q <= sel_ad;
            end
          end
        end

        ISSUE: begin
          state <= IDLE;
          if (bus.CLR) begin
            clr_pend <= 1'b1;
            busy_q   <= 1'b1;
          end
        end

        CLEAR: begin
          // No wrap: the last address ends the sweep on the same edge BUSY drops.
          if (clr_cnt == LAST_AD) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + ONE_AD;
            wr_en_q <= 1'b1;
            wr_ad_q <= clr_cnt + ONE_AD;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.GNT0    = gnt0_q;
  assign bus.GNT1    = gnt1_q;
  assign bus.RVALID0 = rvalid0_q;
  assign bus.RVALID1 = rvalid1_q;
  assign bus.RDATA   = bus.M_RD_DT;
  assign bus.BUSY    = busy_q;
  assign bus.M_RD_EN = rd_en_q;
  assign bus.M_WR_EN = wr_en_q;
  assign bus.M_RD_AD = rd_ad_q;
  assign bus.M_WR_AD = wr_ad_q;
  assign bus.M_WR_DT = wr_dt_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Bench for ram_arb_ctrl: directed plan steps plus random traffic, checked
// every cycle against a transaction-level model with its own RAM shadow.
module tb_ram_arb_ctrl;

  logic       CLK;
  logic       RST;
  logic [1:0] dbg_state;

  ram_arb_ctrl_if #(.AW(8), .DW(8)) bus ();

  ram_arb_ctrl #(.AW(8), .DW(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

`ifdef RAM_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- RAM environment ----------------
  logic [7:0] ram_mem [256];
  logic [7:0] ram_rd_dt;

  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
    ram_rd_dt = 8'h00;
  end

  always @(posedge CLK) begin
    if (bus.M_WR_EN) ram_mem[bus.M_WR_AD] <= bus.M_WR_DT;
    if (bus.M_RD_EN) ram_rd_dt <= ram_mem[bus.M_RD_AD];
  end

  assign bus.M_RD_DT = ram_rd_dt;

  // ---------------- counters / check ----------------
  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       g0;
    logic       g1;
    logic       v0;
    logic       v1;
    logic       busy;
    logic       rde;
    logic       wre;
    logic [7:0] rda;
    logic [7:0] wra;
    logic [7:0] wrd;
  } out_t;

  out_t       e;
  out_t       prev_e;
  bit         live;
  bit         pend;
  bit         after_issue;
  int         last_w;
  int         clear_left;
  int         w;
  bit         m_we;
  logic [7:0] m_ad;
  logic [7:0] m_dt;
  logic [7:0] exp_mem [256];
  logic [7:0] exp_q [$];

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    e = '0;
    live = 1'b0;
    pend = 1'b0;
    after_issue = 1'b0;
    last_w = 1;
    clear_left = 0;
  end

  // Predicts the outputs that follow each edge from the inputs seen at it.
  always @(posedge CLK) begin
    prev_e = e;
    e = '0;
    if (RST) begin
      live = 1'b1;
      pend = 1'b0;
      after_issue = 1'b0;
      last_w = 1;
      clear_left = 0;
      exp_q.delete();
    end else begin
      e.v0 = prev_e.g0 && prev_e.rde;
      e.v1 = prev_e.g1 && prev_e.rde;
      if (clear_left > 0) begin
        clear_left--;
        if (clear_left > 0) begin
          e.busy = 1'b1;
          e.wre  = 1'b1;
          e.wra  = 8'(256 - clear_left);
          exp_mem[256 - clear_left] = 8'h00;
        end
      end else if (after_issue) begin
        after_issue = 1'b0;
        if (bus.CLR) pend = 1'b1;
        e.busy = pend;
      end else if (pend || bus.CLR) begin
        pend = 1'b0;
        clear_left = 256;
        e.busy = 1'b1;
        e.wre  = 1'b1;
        e.wra  = 8'h00;
        exp_mem[0] = 8'h00;
      end else if (bus.REQ0 || bus.REQ1) begin
        if (bus.REQ0 && bus.REQ1) w = FIXED ? 0 : 1 - last_w;
        else w = bus.REQ1 ? 1 : 0;
        if (!FIXED) last_w = w;
        after_issue = 1'b1;
        m_we = (w == 1) ? bus.WE1 : bus.WE0;
        m_ad = (w == 1) ? bus.AD1 : bus.AD0;
        m_dt = (w == 1) ? bus.DT1 : bus.DT0;
        if (w == 1) e.g1 = 1'b1;
        else e.g0 = 1'b1;
        if (m_we) begin
          e.wre = 1'b1;
          e.wra = m_ad;
          e.wrd = m_dt;
          exp_mem[m_ad] = m_dt;
        end else begin
          e.rde = 1'b1;
          e.rda = m_ad;
          exp_q.push_back(exp_mem[m_ad]);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] exp_rd;

  always @(negedge CLK) begin
    if (live) begin
      chk("gnt0",    32'(bus.GNT0),    32'(e.g0));
      chk("gnt1",    32'(bus.GNT1),    32'(e.g1));
      chk("rvalid0", 32'(bus.RVALID0), 32'(e.v0));
      chk("rvalid1", 32'(bus.RVALID1), 32'(e.v1));
      chk("busy",    32'(bus.BUSY),    32'(e.busy));
      chk("m_rd_en", 32'(bus.M_RD_EN), 32'(e.rde));
      chk("m_wr_en", 32'(bus.M_WR_EN), 32'(e.wre));
      chk("m_rd_ad", 32'(bus.M_RD_AD), 32'(e.rda));
      chk("m_wr_ad", 32'(bus.M_WR_AD), 32'(e.wra));
      chk("m_wr_dt", 32'(bus.M_WR_DT), 32'(e.wrd));
      chk("en_excl", 32'(bus.M_RD_EN && bus.M_WR_EN), 32'(0));
      chk("gnt_excl", 32'(bus.GNT0 && bus.GNT1), 32'(0));
      if (bus.RVALID0 || bus.RVALID1) begin
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", 32'(1), 32'(0));
        end else begin
          exp_rd = exp_q.pop_front();
          chk("rdata", 32'(bus.RDATA), 32'(exp_rd));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    bus.WE0  = 1'b0; bus.WE1  = 1'b0;
    bus.AD0  = 8'h00; bus.AD1 = 8'h00;
    bus.DT0  = 8'h00; bus.DT1 = 8'h00;
    bus.CLR  = 1'b0;
  endtask

  // Raise a request and hold it until granted (bounded); returns cycles waited.
  task automatic issue_op(input int port, input bit we, input logic [7:0] ad,
                          input logic [7:0] dt, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    if (port == 0) begin
      bus.REQ0 = 1'b1; bus.WE0 = we; bus.AD0 = ad; bus.DT0 = dt;
    end else begin
      bus.REQ1 = 1'b1; bus.WE1 = we; bus.AD1 = ad; bus.DT1 = dt;
    end
    while (!got && waited < 400) begin
      tick();
      waited++;
      got = (port == 0) ? bus.GNT0 : bus.GNT1;
    end
    chk("grant_seen", 32'(got), 32'(1));
    if (port == 0) bus.REQ0 = 1'b0;
    else bus.REQ1 = 1'b0;
  endtask

  task automatic read_check(input int port, input logic [7:0] ad, input logic [7:0] exp_dt,
                            input string name);
    int waited;
    issue_op(port, 1'b0, ad, 8'h00, waited);
    chk({name, "_rd_ad"}, 32'(bus.M_RD_AD), 32'(ad));
    tick();
    chk({name, "_rvalid"}, 32'((port == 0) ? bus.RVALID0 : bus.RVALID1), 32'(1));
    chk({name, "_rvalid_other"}, 32'((port == 0) ? bus.RVALID1 : bus.RVALID0), 32'(0));
    chk({name, "_rdata"}, 32'(bus.RDATA), 32'(exp_dt));
  endtask

  function automatic logic [7:0] rand_ad();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 15));
  endfunction

  // ---------------- main sequence ----------------
  int waited;
  int n;
  int bad;
  int nz;
  bit g0;
  bit g1;

  initial begin
    n_chk = 0;
    n_fail = 0;
    RST = 1'b1;
    idle_inputs();
    repeat (3) tick();

    // reset state
    chk("rst_gnt",   32'({bus.GNT0, bus.GNT1}), 32'(0));
    chk("rst_rv",    32'({bus.RVALID0, bus.RVALID1}), 32'(0));
    chk("rst_en",    32'({bus.M_RD_EN, bus.M_WR_EN}), 32'(0));
    chk("rst_busy",  32'(bus.BUSY), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(0));
    RST = 1'b0;
    tick();

    // write 0xA5 to 0x10 from requester 0, read it back through requester 1
    issue_op(0, 1'b1, 8'h10, 8'hA5, waited);
    chk("wr_latency", 32'(waited), 32'(1));
    chk("wr_en",      32'(bus.M_WR_EN), 32'(1));
    chk("wr_ad",      32'(bus.M_WR_AD), 32'h10);
    chk("wr_dt",      32'(bus.M_WR_DT), 32'hA5);
    tick();
    read_check(1, 8'h10, 8'hA5, "rd1");
    tick();

    // both requesters reading continuously
    bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.AD0 = 8'h01;
    bus.REQ1 = 1'b1; bus.WE1 = 1'b0; bus.AD1 = 8'h02;
    for (int i = 1; i <= 16; i++) begin
      tick();
      g0 = FIXED ? (i % 2 == 1) : (i % 4 == 1);
      g1 = FIXED ? 1'b0 : (i % 4 == 3);
      chk("arb_gnt0", 32'(bus.GNT0), 32'(g0));
      chk("arb_gnt1", 32'(bus.GNT1), 32'(g1));
    end
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    repeat (2) tick();

    // bulk clear after writing 0x3C to 0xFF
    issue_op(0, 1'b1, 8'hFF, 8'h3C, waited);
    tick();
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    n = 0;
    bad = 0;
    while (bus.BUSY && n < 300) begin
      if (!(bus.M_WR_EN && bus.M_WR_AD == n[7:0] && bus.M_WR_DT == 8'h00)) bad++;
      n++;
      tick();
    end
    chk("clr_cycles", 32'(n), 32'd256);
    chk("clr_bad_writes", 32'(bad), 32'd0);
    nz = 0;
    for (int i = 0; i < 256; i++) if (ram_mem[i] != 8'h00) nz++;
    chk("clr_ram_nonzero", 32'(nz), 32'd0);
    read_check(0, 8'hFF, 8'h00, "rd_after_clr");
    tick();

    // CLR in the same cycle as a read ISSUE
    issue_op(1, 1'b1, 8'h20, 8'h5A, waited);
    tick();
    bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.AD0 = 8'h20;
    tick();
    chk("cli_gnt0", 32'(bus.GNT0), 32'(1));
    chk("cli_rd_en", 32'(bus.M_RD_EN), 32'(1));
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    chk("cli_rvalid0", 32'(bus.RVALID0), 32'(1));
    chk("cli_rdata",   32'(bus.RDATA), 32'h5A);
    chk("cli_busy",    32'(bus.BUSY), 32'(1));
    chk("cli_idle_wr", 32'(bus.M_WR_EN), 32'(0));
    tick();
    chk("cli_clear_start", 32'({bus.M_WR_EN, bus.M_WR_AD}), 32'h100);
    n = 0;
    while (bus.BUSY && n < 300) begin
      chk("cli_no_gnt", 32'(bus.GNT0), 32'(0));
      n++;
      tick();
    end
    chk("cli_clear_len", 32'(n), 32'd256);
    tick();
    chk("cli_gnt_after", 32'(bus.GNT0), 32'(1));
    bus.REQ0 = 1'b0;
    tick();
    chk("cli_rdata_zero", 32'({bus.RVALID0, bus.RDATA}), 32'h100);
    tick();

    // reset in the middle of a clear
    issue_op(0, 1'b1, 8'h80, 8'h99, waited);
    tick();
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    n = 0;
    while (!(bus.M_WR_EN && bus.M_WR_AD == 8'h40) && n < 300) begin
      n++;
      tick();
    end
    chk("mid_clr_reached", 32'(n), 32'h40);
    RST = 1'b1;
    tick();
    chk("mrst_outs", 32'({bus.GNT0, bus.GNT1, bus.RVALID0, bus.RVALID1,
                          bus.BUSY, bus.M_RD_EN, bus.M_WR_EN}), 32'(0));
    chk("mrst_addr", 32'({bus.M_RD_AD, bus.M_WR_AD, bus.M_WR_DT}), 32'(0));
    chk("mrst_state", 32'(dbg_state), 32'(0));
    RST = 1'b0;
    tick();
    read_check(0, 8'h80, 8'h99, "rd_kept");
    read_check(1, 8'h3F, 8'h00, "rd_cleared");
    tick();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if (bus.REQ0 && bus.GNT0) bus.REQ0 = 1'b0;
      if (bus.REQ1 && bus.GNT1) bus.REQ1 = 1'b0;
      if (!bus.REQ0 && $urandom_range(0, 2) == 0) begin
        bus.REQ0 = 1'b1; bus.WE0 = 1'($urandom_range(0, 1));
        bus.AD0 = rand_ad(); bus.DT0 = 8'($urandom);
      end
      if (!bus.REQ1 && $urandom_range(0, 2) == 0) begin
        bus.REQ1 = 1'b1; bus.WE1 = 1'($urandom_range(0, 1));
        bus.AD1 = rand_ad(); bus.DT1 = 8'($urandom);
      end
      bus.CLR = ($urandom_range(0, 599) == 0);
      tick();
    end
    idle_inputs();
    n = 0;
    while (bus.BUSY && n < 400) begin
      n++;
      tick();
    end
    chk("drain_busy", 32'(bus.BUSY), 32'(0));
    repeat (4) tick();
    chk("reads_outstanding", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
